// File: rtl/vram_scheduler_pkg.sv
// Shared constants, swap FSM encoding and address helper for the framebuffer
// scheduler and its satellite blocks.
package vram_scheduler_pkg;

    localparam int H_PIX     = 320;
    localparam int V_PIX     = 240;
    localparam int BUF_W     = 17;
    localparam int DATA_W    = 12;
    localparam int FB_PIXELS = H_PIX * V_PIX;

    typedef enum logic {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_state_t;

    // Addresses past the last stored pixel are acknowledged but never written.
    function automatic logic fb_addr_ok(input logic [BUF_W-1:0] addr);
        return (addr < BUF_W'(FB_PIXELS));
    endfunction

endpackage

// File: rtl/vram_scheduler_if.sv
// Writer handshake and single-port RAM bus, named from the scheduler's side.
interface vram_scheduler_if;
    import vram_scheduler_pkg::*;

    logic                i_wr_req;
    logic [BUF_W-1:0]    i_wr_addr;
    logic [DATA_W-1:0]   i_wr_data;
    logic                o_wr_ack;
    logic [BUF_W:0]      o_mem_addr;
    logic                o_mem_we;
    logic [DATA_W-1:0]   o_mem_wdata;
    logic [DATA_W-1:0]   i_mem_rdata;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ack, o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ack, o_mem_addr, o_mem_we, o_mem_wdata
    );

endinterface

// File: rtl/vram_scan_addr.sv
// Maps a 640x480 scan position onto the 320x240 pixel-doubled buffer address
// using shift-add (line * 320 = line * 256 + line * 64).
module vram_scan_addr
    import vram_scheduler_pkg::*;
(
    input  logic [9:0]       i_hidx,
    input  logic [8:0]       i_vidx,
    output logic [BUF_W-1:0] o_addr
);

    logic [BUF_W-1:0] w_line;
    logic [BUF_W-1:0] w_col;
    logic             w_unused_lsb;

    assign w_line       = {{(BUF_W-8){1'b0}}, i_vidx[8:1]};
    assign w_col        = {{(BUF_W-9){1'b0}}, i_hidx[9:1]};
    assign o_addr       = (w_line << 8) + (w_line << 6) + w_col;
    // Doubling discards the low index bit on both axes.
    assign w_unused_lsb = i_hidx[0] ^ i_vidx[0];

endmodule

// File: rtl/vram_scheduler.sv
// Shares one single-port framebuffer RAM between VGA scan-out and a drawing
// engine, with double buffering swapped at the frame boundary.
module vram_scheduler
    import vram_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        i_sclr,
    input  logic        i_px_clk,
    input  logic        i_haddr_enb,
    input  logic [9:0]  i_hidx,
    input  logic        i_vaddr_enb,
    input  logic [8:0]  i_vidx,
    input  logic        i_frame_en,
    input  logic        i_swap_req,
    output logic        o_swap_ack,
    output logic        o_front,
    output logic [3:0]  o_vga_red,
    output logic [3:0]  o_vga_green,
    output logic [3:0]  o_vga_blue,
    vram_scheduler_if.slave bus
);

    logic              w_visible;
    logic              w_scan;
    logic [BUF_W-1:0]  w_scan_addr;

    logic [BUF_W:0]    r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wr_ack;

    swap_state_t       r_swap_state;
    logic              r_front;
    logic              r_swap_ack;

    logic              r_s1_vld;
    logic              r_s1_vis;
    logic              r_s2_vld;
    logic              r_s2_vis;
    logic [DATA_W-1:0] r_s2_pix;
    logic [DATA_W-1:0] r_vga;

    assign w_visible = ~i_haddr_enb & ~i_vaddr_enb;
    assign w_scan    = i_px_clk & w_visible;

    vram_scan_addr u_scan_addr (
        .i_hidx (i_hidx),
        .i_vidx (i_vidx),
        .o_addr (w_scan_addr)
    );

    // RAM arbiter: scan-out first, then the writer; scans never come back-to-back.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_wr_ack    <= 1'b0;
        end else if (w_scan) begin
            r_mem_addr  <= {r_front, w_scan_addr};
            r_mem_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end else if (bus.i_wr_req) begin
            r_mem_addr  <= {~r_front, bus.i_wr_addr};
            r_mem_we    <= fb_addr_ok(bus.i_wr_addr);
            r_mem_wdata <= bus.i_wr_data;
            r_wr_ack    <= 1'b1;
        end else begin
            r_mem_we    <= 1'b0;
            r_wr_ack    <= 1'b0;
        end
    end

    // Swap FSM: a request arms the swap, the next frame boundary applies it.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            r_swap_state <= SWAP_IDLE;
            r_front      <= 1'b0;
            r_swap_ack   <= 1'b0;
        end else begin
            case (r_swap_state)
                SWAP_IDLE: begin
                    r_swap_ack <= 1'b0;
                    if (i_swap_req) begin
                        r_swap_state <= SWAP_PEND;
                    end else begin
                        r_swap_state <= SWAP_IDLE;
                    end
                end
                SWAP_PEND: begin
                    if (i_frame_en) begin
                        r_swap_state <= SWAP_IDLE;
                        r_front      <= ~r_front;
                        r_swap_ack   <= 1'b1;
                    end else begin
                        r_swap_state <= SWAP_PEND;
                        r_swap_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_swap_state <= SWAP_IDLE;
                    r_swap_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Colour pipeline: visibility travels with the read data and blanks the pins.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            r_s1_vld <= 1'b0;
            r_s1_vis <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_vis <= 1'b0;
            r_s2_pix <= '0;
            r_vga    <= '0;
        end else begin
            r_s1_vld <= i_px_clk;
            r_s1_vis <= w_visible;
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_vis <= r_s1_vis;
                r_s2_pix <= bus.i_mem_rdata;
            end else begin
                r_s2_vis <= r_s2_vis;
                r_s2_pix <= r_s2_pix;
            end
            if (r_s2_vld) begin
                r_vga <= r_s2_vis ? r_s2_pix : {DATA_W{1'b0}};
            end else begin
                r_vga <= r_vga;
            end
        end
    end

    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_wr_ack    = r_wr_ack;
    assign o_front         = r_front;
    assign o_swap_ack      = r_swap_ack;
    assign o_vga_red       = r_vga[11:8];
    assign o_vga_green     = r_vga[7:4];
    assign o_vga_blue      = r_vga[3:0];

endmodule

// File: tb/tb_vram_scheduler.sv
// Scoreboard bench for vram_scheduler: random scan/write/swap traffic checked
// against a frame-level model of the two buffers.
module tb_vram_scheduler;
    import vram_scheduler_pkg::*;

    localparam int AW     = BUF_W + 1;
    localparam int RAM_SZ = 1 << AW;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic              we;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic i_sclr, i_px_clk, i_haddr_enb, i_vaddr_enb, i_frame_en, i_swap_req;
    logic [9:0] i_hidx;
    logic [8:0] i_vidx;
    logic o_swap_ack, o_front;
    logic [3:0] o_vga_red, o_vga_green, o_vga_blue;

    vram_scheduler_if bus();

    vram_scheduler dut (
        .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
        .i_haddr_enb(i_haddr_enb), .i_hidx(i_hidx),
        .i_vaddr_enb(i_vaddr_enb), .i_vidx(i_vidx),
        .i_frame_en(i_frame_en), .i_swap_req(i_swap_req),
        .o_swap_ack(o_swap_ack), .o_front(o_front),
        .o_vga_red(o_vga_red), .o_vga_green(o_vga_green), .o_vga_blue(o_vga_blue),
        .bus(bus)
    );

    always #10 clk = ~clk;

    // RAM behaviour: untouched cells hold a fixed pattern, pokes override it.
    logic [DATA_W-1:0] ram       [RAM_SZ];
    bit                wr_mark   [RAM_SZ];
    logic [DATA_W-1:0] poke_val  [RAM_SZ];
    bit                poke_mark [RAM_SZ];
    logic [DATA_W-1:0] model_val [RAM_SZ];
    bit                model_mark[RAM_SZ];

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'((a * 37) ^ (a >> 4) ^ 32'h5A3);
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_we) begin
            ram[bus.o_mem_addr]     <= bus.o_mem_wdata;
            wr_mark[bus.o_mem_addr] <= 1'b1;
        end
    end

    assign bus.i_mem_rdata = wr_mark[bus.o_mem_addr] ? ram[bus.o_mem_addr] :
                             (poke_mark[bus.o_mem_addr] ? poke_val[bus.o_mem_addr] :
                              pat(int'(bus.o_mem_addr)));

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit model_front = 1'b0;
    bit model_pend = 1'b0;
    bit px_prev = 1'b0;
    int wr_wait = 0;

    logic [AW-1:0]     addr_q[$];
    logic [DATA_W-1:0] col_q[$];
    wr_exp_t           wr_q[$];
    bit                swap_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [AW-1:0] a);
        if (model_mark[a]) return model_val[a];
        if (poke_mark[a]) return poke_val[a];
        return pat(int'(a));
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        poke_val[a]  = d;
        poke_mark[a] = 1'b1;
    endtask

    task automatic issue_write(input int addr, input logic [DATA_W-1:0] data);
        wr_exp_t e;
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = BUF_W'(addr);
        bus.i_wr_data = data;
        e.addr = {~model_front, BUF_W'(addr)};
        e.we   = (addr < FB_PIXELS);
        e.data = data;
        wr_q.push_back(e);
        if (e.we) begin
            model_val[e.addr]  = data;
            model_mark[e.addr] = 1'b1;
        end
        wr_wait = 0;
    endtask

    // One clock of stimulus; expectations are queued before the edge they belong to.
    task automatic cycle(input bit px, input bit hb, input bit vb, input int h, input int v, input bit fe);
        logic [AW-1:0] a;
        i_px_clk    = px;
        i_haddr_enb = hb;
        i_vaddr_enb = vb;
        i_hidx      = 10'(h);
        i_vidx      = 9'(v);
        i_frame_en  = fe;
        if (px) begin
            if (!hb && !vb) begin
                a = {model_front, BUF_W'((v / 2) * H_PIX + (h / 2))};
                addr_q.push_back(a);
                col_q.push_back(model_read(a));
            end else begin
                col_q.push_back('0);
            end
        end
        if (!model_pend) begin
            if (i_swap_req) model_pend = 1'b1;
        end else if (fe) begin
            model_pend  = 1'b0;
            model_front = ~model_front;
            swap_q.push_back(model_front);
        end
        @(posedge clk);
        #2;
        px_prev = px;
        if (bus.i_wr_req) begin
            if (bus.o_wr_ack) begin
                bus.i_wr_req = 1'b0;
                wr_wait = 0;
            end else begin
                wr_wait++;
                if (wr_wait >= 2) begin
                    chk("wr_grant_timeout", wr_wait, 1);
                    bus.i_wr_req = 1'b0;
                    wr_q.delete();
                    wr_wait = 0;
                end
            end
        end
        if (i_swap_req && o_swap_ack) i_swap_req = 1'b0;
        i_px_clk   = 1'b0;
        i_frame_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a RAM op, ack or pixel.
    initial begin
        bit d0, d1, d2, s0;
        logic [DATA_W-1:0] vga_exp;
        logic [AW-1:0] last_addr;
        logic [AW-1:0] aexp;
        wr_exp_t e;
        bit f;
        d0 = 0; d1 = 0; d2 = 0; vga_exp = '0; last_addr = '0;
        forever begin
            @(posedge clk);
            if (!mon_en) begin
                d0 = 0; d1 = 0; d2 = 0; vga_exp = '0; last_addr = '0;
                continue;
            end
            d2 = d1;
            d1 = d0;
            d0 = i_px_clk;
            s0 = i_px_clk && !i_haddr_enb && !i_vaddr_enb;
            #1;
            if (s0) begin
                if (addr_q.size() == 0) chk("scan_unexpected", 1, 0);
                else begin
                    aexp = addr_q.pop_front();
                    chk("scan_addr", bus.o_mem_addr, aexp);
                    chk("scan_we", bus.o_mem_we, 0);
                    chk("scan_no_ack", bus.o_wr_ack, 0);
                    last_addr = aexp;
                end
            end else if (bus.o_wr_ack) begin
                if (wr_q.size() == 0) chk("wr_ack_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", bus.o_mem_addr, e.addr);
                    chk("wr_we", bus.o_mem_we, e.we);
                    if (e.we) chk("wr_data", bus.o_mem_wdata, e.data);
                    last_addr = e.addr;
                end
            end else begin
                chk("idle_we", bus.o_mem_we, 0);
                chk("idle_addr_hold", bus.o_mem_addr, last_addr);
            end
            if (d2) begin
                if (col_q.size() == 0) chk("pixel_unexpected", 1, 0);
                else vga_exp = col_q.pop_front();
            end
            chk("vga", {o_vga_red, o_vga_green, o_vga_blue}, vga_exp);
            if (o_swap_ack) begin
                if (swap_q.size() == 0) chk("swap_ack_unexpected", 1, 0);
                else begin
                    f = swap_q.pop_front();
                    chk("swap_front", o_front, f);
                end
            end else if (swap_q.size() != 0) begin
                chk("swap_ack_missing", 0, 1);
                void'(swap_q.pop_front());
            end
        end
    end

    initial begin
        bit px, hb, vb, fe;
        i_sclr = 1'b1; i_px_clk = 1'b0; i_haddr_enb = 1'b1; i_vaddr_enb = 1'b1;
        i_hidx = '0; i_vidx = '0; i_frame_en = 1'b0; i_swap_req = 1'b0;
        bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        repeat (3) @(posedge clk);
        #2 i_sclr = 1'b0;

        // Get the front buffer to 1 and a write in flight, then reset mid-cycle.
        i_swap_req = 1'b1;
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 1);
        cycle(1, 0, 0, 20, 20, 0);
        idle(2);
        i_px_clk = 1'b1; i_haddr_enb = 1'b0; i_vaddr_enb = 1'b0;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 17'd7; bus.i_wr_data = 12'h777;
        @(posedge clk);
        #5 i_sclr = 1'b1;
        #1;
        chk("rst_vga", {o_vga_red, o_vga_green, o_vga_blue}, 0);
        chk("rst_front", o_front, 0);
        chk("rst_we", bus.o_mem_we, 0);
        chk("rst_ack", bus.o_wr_ack, 0);
        bus.i_wr_req = 1'b0; i_px_clk = 1'b0; i_swap_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 i_sclr = 1'b0;
        model_front = 1'b0; model_pend = 1'b0; px_prev = 1'b0;
        addr_q.delete(); col_q.delete(); wr_q.delete(); swap_q.delete();
        @(posedge clk);
        #2 mon_en = 1'b1;

        // Scan at (5,3) colliding with a write: scan wins, write follows.
        poke({1'b0, 17'd322}, 12'hA5C);
        issue_write(100, 12'hFFF);
        cycle(1, 0, 0, 5, 3, 0);
        chk("coincident_no_ack", bus.o_wr_ack, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        chk("pixel_a5c", {o_vga_red, o_vga_green, o_vga_blue}, 12'hA5C);

        issue_write(FB_PIXELS, 12'h123);
        idle(3);

        i_swap_req = 1'b1;
        idle(4);
        chk("front_before_frame", o_front, 0);
        cycle(0, 1, 1, 0, 0, 1);
        chk("front_after_frame", o_front, 1);
        issue_write(5, 12'h0AB);
        idle(3);

        i_swap_req = 1'b1;
        cycle(0, 1, 1, 0, 0, 1);
        chk("swap_same_cycle_front", o_front, 1);
        chk("swap_same_cycle_ack", o_swap_ack, 0);
        idle(3);
        cycle(0, 1, 1, 0, 0, 1);
        chk("second_swap_front", o_front, 0);

        for (int i = 0; i < 12; i++) cycle(i[0], 1, 0, 100 + i, 50, 0);
        idle(3);
        chk("blank_vga", {o_vga_red, o_vga_green, o_vga_blue}, 0);

        for (int i = 0; i < 4000; i++) begin
            px = !px_prev && ($urandom_range(0, 2) != 0);
            hb = ($urandom_range(0, 7) == 0);
            vb = ($urandom_range(0, 15) == 0);
            if (!bus.i_wr_req && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    issue_write(int'($urandom_range(FB_PIXELS, (1 << BUF_W) - 1)), DATA_W'($urandom));
                else
                    issue_write(int'($urandom_range(0, FB_PIXELS - 1)), DATA_W'($urandom));
            end
            if (!i_swap_req && $urandom_range(0, 60) == 0) i_swap_req = 1'b1;
            fe = !bus.i_wr_req && ($urandom_range(0, 40) == 0);
            cycle(px, hb, vb, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), fe);
        end

        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 0, 0, i_swap_req && !bus.i_wr_req && i[0]);
        chk("drain_scan_q", addr_q.size(), 0);
        chk("drain_col_q", col_q.size(), 0);
        chk("drain_wr_q", wr_q.size(), 0);
        chk("drain_swap_q", swap_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
